// File: rtl/warp_issue_scheduler_pkg.sv
// Purpose: shared constants and helpers for the warp issue scheduler.
//   - OP_* : lane opcode encodings (OP_NOP makes the lanes hold state)
//   - DEF_NUM_WARPS / DEF_LANES : default sizing
//   - wid_width() : width of a warp id for a given warp count
package gpu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam int DEF_NUM_WARPS = 4;
    localparam int DEF_LANES     = 8;

    function automatic int wid_width(input int num_warps);
        return (num_warps <= 2) ? 1 : $clog2(num_warps);
    endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Purpose: bundle of the warp request handshake and the lane-array issue /
// writeback outputs of the warp issue scheduler.
//   req_valid/req_opcode/req_mask/issue_stall : driven by the warp buffers
//   req_ready, issue_*, lane_*, wb_*, warp_busy, issue_count : driven by
//   the scheduler
// Handshake: warp w's instruction is consumed on a cycle where
// req_valid[w] and req_ready[w] are both high; req_ready is one-hot or zero,
// and the warp buffer must hold its opcode/mask stable while valid.
interface warp_issue_scheduler_if
    import gpu_sched_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int LANES     = DEF_LANES,
    parameter int CNT_W     = 16,
    parameter int WID_W     = wid_width(NUM_WARPS)
);
    logic [NUM_WARPS-1:0]       req_valid;
    logic [2*NUM_WARPS-1:0]     req_opcode;
    logic [LANES*NUM_WARPS-1:0] req_mask;
    logic [NUM_WARPS-1:0]       req_ready;
    logic                       issue_stall;
    logic                       issue_valid;
    logic [WID_W-1:0]           issue_warp;
    logic [1:0]                 lane_opcode;
    logic [LANES-1:0]           lane_active;
    logic                       wb_valid;
    logic [WID_W-1:0]           wb_warp;
    logic [NUM_WARPS-1:0]       warp_busy;
    logic [CNT_W-1:0]           issue_count;

    modport master (
        output req_valid, req_opcode, req_mask, issue_stall,
        input  req_ready, issue_valid, issue_warp, lane_opcode, lane_active,
               wb_valid, wb_warp, warp_busy, issue_count
    );

    modport slave (
        input  req_valid, req_opcode, req_mask, issue_stall,
        output req_ready, issue_valid, issue_warp, lane_opcode, lane_active,
               wb_valid, wb_warp, warp_busy, issue_count
    );

endinterface

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Purpose: combinational round-robin arbiter. Searches req_i starting at
// ptr_i, wrapping modulo NUM_WARPS, and returns the first requester.
//   req_i    : request vector
//   ptr_i    : highest-priority index this cycle
//   grant_o  : one-hot grant, zero when nothing requests
//   winner_o : encoded winner (equals ptr_i when any_o is low)
//   any_o    : a grant was made
module rr_arbiter
    import gpu_sched_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int WID_W     = wid_width(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] req_i,
    input  logic [WID_W-1:0]     ptr_i,
    output logic [NUM_WARPS-1:0] grant_o,
    output logic [WID_W-1:0]     winner_o,
    output logic                 any_o
);

    always_comb begin
        logic [WID_W-1:0] idx;
        any_o    = 1'b0;
        winner_o = ptr_i;
        idx      = ptr_i;
        // NUM_WARPS is a power of two, so the WID_W-bit add wraps for free.
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = ptr_i + WID_W'(i);
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
        grant_o = any_o ? (NUM_WARPS'(1) << winner_o) : '0;
    end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Purpose: shares one SIMD lane array between NUM_WARPS warps. Each cycle a
// round-robin winner among eligible warps (valid, not in flight, no stall)
// is granted; its opcode and lane mask are registered onto the lane
// controls the next cycle, and the writeback tag follows one cycle later.
// A warp stays busy from the cycle after its grant through its writeback.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request handshake, lane controls, writeback, status
module warp_issue_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int LANES     = DEF_LANES,
    parameter int CNT_W     = 16,
    parameter int WID_W     = wid_width(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    warp_issue_scheduler_if.slave  bus
);

    logic [WID_W-1:0]     ptr_q, ptr_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [WID_W-1:0]     issue_warp_q, issue_warp_d;
    logic [1:0]           lane_opcode_q, lane_opcode_d;
    logic [LANES-1:0]     lane_active_q, lane_active_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [WID_W-1:0]     wb_warp_q, wb_warp_d;
    logic [NUM_WARPS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] grant;
    logic [WID_W-1:0]     winner;
    logic                 any_grant;
    logic [1:0]           sel_opcode;
    logic [LANES-1:0]     sel_mask;
    logic [NUM_WARPS-1:0] wb_clear;

    assign eligible = bus.req_valid & ~busy_q & {NUM_WARPS{~bus.issue_stall}};

    rr_arbiter #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_arb (
        .req_i    (eligible),
        .ptr_i    (ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .any_o    (any_grant)
    );

    // Ready is combinational; gate with rst_n so it reads 0 during reset
    // even though the request inputs may already be high.
    assign bus.req_ready = grant & {NUM_WARPS{rst_n}};

    assign sel_opcode = bus.req_opcode[2*int'(winner) +: 2];
    assign sel_mask   = bus.req_mask[LANES*int'(winner) +: LANES];
    assign wb_clear   = wb_valid_q ? (NUM_WARPS'(1) << wb_warp_q) : '0;

    always_comb begin
        ptr_d         = any_grant ? winner + WID_W'(1) : ptr_q;
        issue_valid_d = any_grant;
        issue_warp_d  = any_grant ? winner : issue_warp_q;
        lane_active_d = any_grant ? sel_mask : '0;
        // An empty mask still issues but must not disturb the lanes.
        lane_opcode_d = (any_grant && (sel_mask != '0)) ? sel_opcode : OP_NOP;
        wb_valid_d    = issue_valid_q;
        wb_warp_d     = issue_warp_q;
        // A warp cannot be granted while busy, so set and clear never
        // target the same bit in one cycle.
        busy_d        = (busy_q & ~wb_clear) | grant;
        count_d       = (any_grant && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            lane_opcode_q <= '0;
            lane_active_q <= '0;
            wb_valid_q    <= 1'b0;
            wb_warp_q     <= '0;
            busy_q        <= '0;
            count_q       <= '0;
        end else begin
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            lane_opcode_q <= lane_opcode_d;
            lane_active_q <= lane_active_d;
            wb_valid_q    <= wb_valid_d;
            wb_warp_q     <= wb_warp_d;
            busy_q        <= busy_d;
            count_q       <= count_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_warp  = issue_warp_q;
    assign bus.lane_opcode = lane_opcode_q;
    assign bus.lane_active = lane_active_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_warp     = wb_warp_q;
    assign bus.warp_busy   = busy_q;
    assign bus.issue_count = count_q;

endmodule
